// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle ALU control decoder.
// Operation codes, ALUOp/funct encodings and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b0111;
  localparam logic [3:0] OP_DIVU  = 4'b1000;
  localparam logic [3:0] OP_NONE  = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1110;
  localparam logic [3:0] OP_SLL   = 4'b1111;

  localparam logic [2:0] ALUOP_ADDI = 3'b100;
  localparam logic [2:0] ALUOP_ORI  = 3'b101;
  localparam logic [2:0] ALUOP_ANDI = 3'b110;
  localparam logic [2:0] ALUOP_R    = 3'b111;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_control_mc_decode.sv
// Combinational {ALUOp, funct} to ALU operation code map.
// Also flags mult/div instructions and which of them are divides.
module alu_decode
  import alu_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNC_W  = 6
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNC_W-1:0]  alu_function,
  output logic [3:0]         op_code,
  output logic               is_multdiv,
  output logic               is_div
);

  always_comb begin
    op_code    = OP_NONE;
    is_multdiv = 1'b0;
    is_div     = 1'b0;
    unique case (1'b1)
      (alu_op == ALUOP_W'(ALUOP_R)): begin
        case (alu_function)
          FUNC_W'(FN_AND):   op_code = OP_AND;
          FUNC_W'(FN_OR):    op_code = OP_OR;
          FUNC_W'(FN_NOR):   op_code = OP_NOR;
          FUNC_W'(FN_ADD):   op_code = OP_ADD;
          FUNC_W'(FN_SUB):   op_code = OP_SUB;
          FUNC_W'(FN_SLL):   op_code = OP_SLL;
          FUNC_W'(FN_SRL):   op_code = OP_SRL;
          FUNC_W'(FN_MULT): begin
            op_code    = OP_MULT;
            is_multdiv = 1'b1;
          end
          FUNC_W'(FN_MULTU): begin
            op_code    = OP_MULTU;
            is_multdiv = 1'b1;
          end
          FUNC_W'(FN_DIV): begin
            op_code    = OP_DIV;
            is_multdiv = 1'b1;
            is_div     = 1'b1;
          end
          FUNC_W'(FN_DIVU): begin
            op_code    = OP_DIVU;
            is_multdiv = 1'b1;
            is_div     = 1'b1;
          end
          default: op_code = OP_NONE;
        endcase
      end
      (alu_op == ALUOP_W'(ALUOP_ADDI)): op_code = OP_ADD;
      (alu_op == ALUOP_W'(ALUOP_ORI)):  op_code = OP_OR;
      (alu_op == ALUOP_W'(ALUOP_ANDI)): op_code = OP_AND;
      default: op_code = OP_NONE;
    endcase
  end

endmodule

// File: rtl/alu_control_mc.sv
// ALU control decoder with an iterative mult/div sequencer.
// Single-cycle ops decode combinationally; mult/div run DATA_WIDTH steps.
module alu_control_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ALUOP_W    = 3,
  parameter int FUNC_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [FUNC_W-1:0]  ALUFunction,
  input  logic               divisor_zero,
  output logic [3:0]         ALUOperation,
  output logic               iter_en,
  output logic               iter_first,
  output logic               hilo_we,
  output logic               stall,
  output logic               done,
  output logic               div_zero_err
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [3:0]    dec_op;
  logic          dec_multdiv;
  logic          dec_div;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic          abort_q;

  alu_decode #(
    .ALUOP_W(ALUOP_W),
    .FUNC_W (FUNC_W)
  ) u_dec (
    .alu_op      (ALUOp),
    .alu_function(ALUFunction),
    .op_code     (dec_op),
    .is_multdiv  (dec_multdiv),
    .is_div      (dec_div)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= OP_NONE;
      abort_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (valid && dec_multdiv) begin
            op_q <= dec_op;
            cnt  <= '0;
            // zero divisor skips iteration and retires as an abort
            if (dec_div && divisor_zero) begin
              abort_q <= 1'b1;
              state   <= S_WB;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          abort_q <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // reset masks the handshake outputs so a busy unit never retires under it
  always_comb begin
    ALUOperation = (state == S_IDLE) ? dec_op : op_q;
    iter_en      = 1'b0;
    iter_first   = 1'b0;
    hilo_we      = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    div_zero_err = 1'b0;
    unique case (state)
      S_IDLE: stall = !reset && valid && dec_multdiv;
      S_RUN: begin
        iter_en    = !reset;
        iter_first = !reset && (cnt == '0);
        stall      = !reset;
      end
      S_WB: begin
        done         = !reset;
        hilo_we      = !reset && !abort_q;
        div_zero_err = !reset && abort_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc: decode sweep plus scoreboarded mult/div runs.
// A second instance with DATA_WIDTH=8 exercises the short counter.
module tb_alu_control_mc;
  import alu_pkg::*;

  typedef struct {
    logic [3:0] op;
    int         iters;
    int         first;
    logic       hilo;
    logic       dze;
    int         stalls;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [2:0] ALUOp;
  logic [5:0] ALUFunction;
  logic       divisor_zero;
  logic [3:0] ALUOperation;
  logic       iter_en, iter_first, hilo_we, stall, done, div_zero_err;

  logic       v8;
  logic [2:0] aop8;
  logic [5:0] fn8;
  logic       dz8;
  logic [3:0] op8;
  logic       it8, first8, hilo8, stall8, done8, dze8;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  int it_n = 0, first_n = 0, stall_n = 0, opbad = 0, done_total = 0;

  always #5 clk = ~clk;

  alu_control_mc #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp),
    .ALUFunction(ALUFunction), .divisor_zero(divisor_zero),
    .ALUOperation(ALUOperation), .iter_en(iter_en),
    .iter_first(iter_first), .hilo_we(hilo_we), .stall(stall),
    .done(done), .div_zero_err(div_zero_err)
  );

  alu_control_mc #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .valid(v8), .ALUOp(aop8),
    .ALUFunction(fn8), .divisor_zero(dz8),
    .ALUOperation(op8), .iter_en(it8),
    .iter_first(first8), .hilo_we(hilo8), .stall(stall8),
    .done(done8), .div_zero_err(dze8)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] a,
                     input logic [5:0] f, input logic dz);
    valid        = v;
    ALUOp        = a;
    ALUFunction  = f;
    divisor_zero = dz;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("timeout", 0, 1);
  endtask

  // scoreboard monitor for the 32-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      it_n = 0; first_n = 0; stall_n = 0; opbad = 0;
    end else begin
      if (stall) stall_n++;
      if (iter_en) begin
        it_n++;
        if (sb.size() > 0 && ALUOperation != sb[0].op) opbad++;
      end
      if (iter_first) first_n++;
      if (done) begin
        done_total++;
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("wb_op", ALUOperation, e.op);
          chk("iters", it_n, e.iters);
          chk("first", first_n, e.first);
          chk("hilo_we", hilo_we, e.hilo);
          chk("dz_err", div_zero_err, e.dze);
          chk("stalls", stall_n, e.stalls);
          chk("run_op", opbad, 0);
          chk("wb_stall", stall, 0);
        end
        it_n = 0; first_n = 0; stall_n = 0; opbad = 0;
      end
    end
  end

  task automatic run8(input logic [5:0] f, input logic [3:0] exp_op);
    int n = 0, nf = 0;
    bit seen = 0;
    @(posedge clk); #1;
    v8 = 1; aop8 = ALUOP_R; fn8 = f; dz8 = 0;
    @(posedge clk); #1;
    v8 = 0; aop8 = 3'b000; fn8 = 6'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (it8) n++;
      if (first8) nf++;
      if (done8) begin
        seen = 1;
        chk("w8_hilo", hilo8, 1);
        chk("w8_op", op8, exp_op);
        break;
      end
    end
    chk("w8_seen", seen, 1);
    chk("w8_iters", n, 8);
    chk("w8_first", nf, 1);
  endtask

  typedef struct {
    logic [2:0] a;
    logic [5:0] f;
    logic [3:0] e;
  } dec_t;

  dec_t dtab[$];

  initial begin
    int d0;
    dtab = '{
      '{3'b111, 6'b100100, 4'b0000}, '{3'b111, 6'b100101, 4'b0001},
      '{3'b111, 6'b100111, 4'b0010}, '{3'b111, 6'b100000, 4'b0011},
      '{3'b111, 6'b100010, 4'b0100}, '{3'b111, 6'b000000, 4'b1111},
      '{3'b111, 6'b000010, 4'b1110}, '{3'b100, 6'b000000, 4'b0011},
      '{3'b101, 6'b000000, 4'b0001}, '{3'b110, 6'b000000, 4'b0000},
      '{3'b111, 6'b101010, 4'b1001}, '{3'b000, 6'b100000, 4'b1001},
      '{3'b011, 6'b011000, 4'b1001}
    };
    reset = 1;
    drv(0, 3'b000, 6'b0, 0);
    v8 = 0; aop8 = 3'b000; fn8 = 6'b0; dz8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {stall, iter_en, iter_first, hilo_we, done,
                     div_zero_err}, 0);
    chk("rst_op", ALUOperation, 4'b1001);
    chk("rst_outs8", {stall8, it8, first8, hilo8, done8, dze8}, 0);
    reset = 0;

    foreach (dtab[i]) begin
      @(posedge clk); #1;
      drv(1, dtab[i].a, dtab[i].f, 0);
      #2;
      chk("dec", ALUOperation, dtab[i].e);
      chk("dec_stall", stall, 0);
    end

    // MULT full sequence
    @(posedge clk); #1;
    drv(1, ALUOP_R, 6'b011000, 0);
    sb.push_back('{4'b0101, 32, 1, 1'b1, 1'b0, 33});
    @(posedge clk); #1;
    drv(0, 3'b000, 6'b0, 0);
    wait_done();

    // DIVU with zero divisor aborts
    @(posedge clk); #1;
    drv(1, ALUOP_R, 6'b011011, 1);
    sb.push_back('{4'b1000, 0, 0, 1'b0, 1'b1, 1});
    @(posedge clk); #1;
    drv(0, 3'b000, 6'b0, 0);
    #1;
    chk("abort_done", done, 1);
    wait_done();

    // DIV with an ADD presented mid-run
    @(posedge clk); #1;
    drv(1, ALUOP_R, 6'b011010, 0);
    sb.push_back('{4'b0111, 32, 1, 1'b1, 1'b0, 33});
    @(posedge clk); #1;
    drv(0, 3'b000, 6'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    drv(1, ALUOP_R, 6'b100000, 0);
    #2;
    chk("busy_op", ALUOperation, 4'b0111);
    chk("busy_stall", stall, 1);
    wait_done();
    @(posedge clk); #2;
    chk("idle_add", ALUOperation, 4'b0011);
    chk("idle_quiet", {stall, iter_en, done}, 0);
    #1;
    drv(1, ALUOP_R, 6'b011000, 0);
    sb.push_back('{4'b0101, 32, 1, 1'b1, 1'b0, 33});
    @(posedge clk); #1;
    drv(0, 3'b000, 6'b0, 0);
    wait_done();

    // reset at RUN step 10
    @(posedge clk); #1;
    drv(1, ALUOP_R, 6'b011000, 0);
    sb.push_back('{4'b0101, 32, 1, 1'b1, 1'b0, 33});
    @(posedge clk); #1;
    drv(0, 3'b000, 6'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_iter", iter_en, 1);
    reset = 1;
    sb.delete();
    d0 = done_total;
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("post_rst_outs", {stall, iter_en, iter_first, hilo_we, done,
                          div_zero_err}, 0);
    chk("post_rst_op", ALUOperation, 4'b1001);
    repeat (40) @(posedge clk);
    chk("no_done", done_total, d0);

    // 8-bit instance, twice to cover counter wrap
    run8(6'b011001, 4'b0110);
    run8(6'b011011, 4'b1000);

    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_control_mc.md
# alu_control_mc

Parametrised multi-cycle successor to the single-cycle ALU control decoder. It decodes ALUOp/ALUFunction into the 4-bit ALU operation code, as before. It also sequences the iterative MULT/MULTU/DIV/DIVU unit over DATA_WIDTH steps, stalling the pipeline and writing HI/LO on completion. It sits between the main control unit and the ALU/mult-div datapath in the execute stage.

## Interface
- DATA_WIDTH, 32, operand width; iteration count per mult/div.
- ALUOP_W, 3, ALUOp width.
- FUNC_W, 6, funct field width.
- One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- valid  in  1  decode inputs carry a real instruction this cycle.
- ALUOp  in  ALUOP_W  op class from main control.
- ALUFunction  in  FUNC_W  instruction funct field.
- divisor_zero  in  1  divisor operand is zero; sampled with valid.
- ALUOperation  out  4  ALU operation code.
- iter_en  out  1  mult/div datapath performs one step this cycle.
- iter_first  out  1  first step; datapath loads operands.
- hilo_we  out  1  write HI/LO this cycle.
- stall  out  1  hold the pipeline front end.
- done  out  1  one-cycle pulse when a mult/div retires.
- div_zero_err  out  1  one-cycle pulse when a divide is aborted for a zero divisor.

## Operation
- Single-cycle decode is combinational from {ALUOp, ALUFunction} while in IDLE:
  - R-type (ALUOp=111): AND→0000, OR→0001, NOR→0010, ADD→0011, SUB→0100, SLL→1111, SRL→1110.
  - I-type: ADDI (100)→0011, ORI (101)→0001, ANDI (110)→0000.
  - Anything else→1001.
- New R-type codes:
  - MULT (011000)→0101.
  - MULTU (011001)→0110.
  - DIV (011010)→0111.
  - DIVU (011011)→1000.
- FSM states are IDLE, RUN and WB; counter cnt is $clog2(DATA_WIDTH) bits.
- IDLE:
  - On valid with a mult/div code, latch the code into op_q. Go to RUN with cnt=0; stall=1 from this cycle.
  - Exception: DIV/DIVU with divisor_zero=1 goes to WB with the abort flag set, skipping RUN.
  - Any other valid: stay in IDLE; no stall.
  - valid=0: all outputs are 0 except ALUOperation.
- RUN:
  - iter_en=1 and stall=1; iter_first=1 only when cnt=0.
  - cnt increments each cycle. When cnt=DATA_WIDTH-1, go to WB; cnt wraps to 0.
- WB (normal):
  - hilo_we=1, done=1, stall=0. Go to IDLE.
- WB (aborted divide):
  - hilo_we=0, div_zero_err=1, done=1, stall=0. Go to IDLE; the abort flag clears.
- While not in IDLE: ALUOperation=op_q; valid and all decode inputs are ignored.
- Reset values:
  - State=IDLE, cnt=0, op_q=1001, abort flag=0.
  - All outputs 0; ALUOperation follows its inputs as in IDLE.
- Reset during RUN/WB: return to IDLE next edge; no hilo_we or done is emitted.

## Timing
- Single-cycle ops: zero latency, combinational.
- Mult/div: accepted at edge T0.
  - iter_en high for cycles T0+1 … T0+DATA_WIDTH.
  - hilo_we and done in cycle T0+DATA_WIDTH+1.
  - Total stall = DATA_WIDTH+1 cycles, counting the accept cycle.
- Zero-divisor abort: accept at T0; done and div_zero_err in T0+1.
- A new instruction may be accepted in the cycle after WB. Back-to-back mult/div incurs no extra bubble beyond WB.
- A valid arriving during the WB cycle is not accepted. Stall is low in WB, so the front end presents it in IDLE on the next cycle.

## Structure
- Shared package alu_pkg holds:
  - The 4-bit ALUOperation localparams (including the new codes).
  - The funct and ALUOp constants.
  - The FSM state enum.
- One sub-module, alu_decode: a purely combinational {ALUOp, ALUFunction}→code map plus an is_multdiv/is_div flag.
- The FSM and counter live in the top module.

## Test plan
- Decode sweep: each R/I encoding with valid=1 gives its code; ALUOp=111 with funct=101010 gives 1001. Stall stays 0 throughout.
- MULT, DATA_WIDTH=32:
  - Exactly 32 iter_en cycles; iter_first only in the first.
  - hilo_we and done in cycle 33 after accept; stall high for 33 cycles.
  - ALUOperation=0101 throughout.
- DIVU with divisor_zero=1: next cycle done=1, div_zero_err=1, hilo_we=0. Zero iter_en cycles.
- Inputs ignored while busy: ADD presented mid-RUN leaves ALUOperation=0111 (DIV), and no second operation is accepted. A MULT then accepted right after WB runs a full 32-step sequence.
- Reset asserted at RUN step 10: next cycle state IDLE and all outputs 0. No hilo_we or done follows.
- DATA_WIDTH=8 instance: 8 iter_en cycles, and the 3-bit cnt wraps correctly.
